// File: rtl/nios_hps_system_pkg.sv
// Shared types and sizing helpers for the system PLL reset sequencer.
package nios_hps_system_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN,
    FAIL
  } seq_state_t;

  // Bits needed to hold any value in 0..max_val, never less than one.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/nios_hps_system_sync2.sv
// Two-flop synchroniser for a single asynchronous level.
module nios_hps_system_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nios_hps_system_pll_rst_seq.sv
// PLL lock monitor and reset sequencer: pulses the PLL reset, waits for a stable
// lock, then releases the per-domain resets one at a time.
module nios_hps_system_pll_rst_seq
  import nios_hps_system_pkg::*;
#(
  parameter int NUM_DOMAINS        = 5,
  parameter int PLL_RST_CYCLES     = 16,
  parameter int LOCK_TIMEOUT       = 65536,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RELEASE_GAP        = 64,
  parameter int MAX_RETRIES        = 3
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   locked,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   sys_ready,
  output logic                   lock_fail,
  output logic [7:0]             lock_loss_count
);

  // One phase timer is shared by all timed states, so it is sized for the longest.
  localparam int RELEASE_SPAN = (NUM_DOMAINS - 1) * RELEASE_GAP;
  localparam int TIMER_MAX    = max_int(max_int(PLL_RST_CYCLES - 1, LOCK_TIMEOUT - 1),
                                        max_int(LOCK_STABLE_CYCLES - 1, RELEASE_SPAN));
  localparam int TW           = cnt_width(TIMER_MAX);
  localparam int RW           = cnt_width(MAX_RETRIES + 1);

  localparam logic [TW-1:0] PLL_RST_LAST = TW'(PLL_RST_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STABLE_LAST  = TW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] RELEASE_LAST = TW'(RELEASE_SPAN);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);
  localparam logic [RW-1:0] RETRY_SAT    = RW'(MAX_RETRIES + 1);

  seq_state_t state, state_next;
  logic [TW-1:0] timer, timer_next;
  logic [RW-1:0] retry_cnt, retry_next;
  logic [7:0] loss_next;
  logic locked_s;

  logic                   pll_rst_d;
  logic [NUM_DOMAINS-1:0] domain_rst_d;
  logic                   sys_ready_d;
  logic                   lock_fail_d;

  nios_hps_system_sync2 u_lock_sync (
    .clk (refclk),
    .rst (rst),
    .d   (locked),
    .q   (locked_s)
  );

  always_ff @(posedge refclk) begin
    if (rst) begin
      state           <= PLL_RST;
      timer           <= '0;
      retry_cnt       <= '0;
      lock_loss_count <= 8'd0;
      pll_rst         <= 1'b1;
      domain_rst      <= '1;
      sys_ready       <= 1'b0;
      lock_fail       <= 1'b0;
    end else begin
      state           <= state_next;
      timer           <= timer_next;
      retry_cnt       <= retry_next;
      lock_loss_count <= loss_next;
      pll_rst         <= pll_rst_d;
      domain_rst      <= domain_rst_d;
      sys_ready       <= sys_ready_d;
      lock_fail       <= lock_fail_d;
    end
  end

  // Lock is always checked before any timer expiry, so a late lock still wins.
  always_comb begin
    state_next = state;
    timer_next = timer;
    retry_next = retry_cnt;
    loss_next  = lock_loss_count;
    case (state)
      PLL_RST: begin
        if (timer == PLL_RST_LAST) begin
          state_next = WAIT_LOCK;
          timer_next = '0;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      WAIT_LOCK: begin
        if (locked_s) begin
          state_next = STABLE;
          timer_next = '0;
        end else if (timer == TIMEOUT_LAST) begin
          timer_next = '0;
          if (retry_cnt != RETRY_SAT) begin
            retry_next = retry_cnt + RW'(1);
          end
          if ((MAX_RETRIES != 0) && (retry_cnt >= RETRY_LIMIT)) begin
            state_next = FAIL;
          end else begin
            state_next = PLL_RST;
          end
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      STABLE: begin
        if (!locked_s) begin
          state_next = WAIT_LOCK;
          timer_next = '0;
        end else if (timer == STABLE_LAST) begin
          state_next = RELEASE;
          timer_next = '0;
        end else begin
          timer_next = timer + TW'(1);
        end
      end
      RELEASE, RUN: begin
        if (!locked_s) begin
          state_next = PLL_RST;
          timer_next = '0;
          if (lock_loss_count != 8'hFF) begin
            loss_next = lock_loss_count + 8'd1;
          end
        end else if (state == RELEASE) begin
          if (timer == RELEASE_LAST) begin
            state_next = RUN;
            timer_next = '0;
            retry_next = '0;
          end else begin
            timer_next = timer + TW'(1);
          end
        end
      end
      FAIL: begin
        state_next = FAIL;
      end
      default: begin
        state_next = PLL_RST;
        timer_next = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    pll_rst_d    = 1'b0;
    domain_rst_d = '1;
    sys_ready_d  = 1'b0;
    lock_fail_d  = 1'b0;
    case (state_next)
      PLL_RST: pll_rst_d = 1'b1;
      RELEASE: begin
        for (int i = 0; i < NUM_DOMAINS; i++) begin
          domain_rst_d[i] = (timer_next < TW'(i * RELEASE_GAP));
        end
      end
      RUN: begin
        domain_rst_d = '0;
        sys_ready_d  = 1'b1;
      end
      FAIL: begin
        pll_rst_d   = 1'b1;
        lock_fail_d = 1'b1;
      end
      default: begin
        pll_rst_d = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_nios_hps_system_pll_rst_seq.sv
// Self-checking bench for the PLL reset sequencer: directed scenarios plus
// randomized lock traffic checked against a cycle-level behavioural model.
module tb_nios_hps_system_pll_rst_seq;

  localparam int ND  = 5;
  localparam int PRC = 4;
  localparam int LTO = 32;
  localparam int LSC = 8;
  localparam int RG  = 2;
  localparam int MR  = 2;
  localparam int OW  = ND + 11;

  localparam int P_PLL    = 0;
  localparam int P_WAIT   = 1;
  localparam int P_STABLE = 2;
  localparam int P_REL    = 3;
  localparam int P_RUN    = 4;
  localparam int P_FAIL   = 5;

  logic          refclk = 1'b0;
  logic          rst    = 1'b1;
  logic          locked = 1'b0;
  logic          pll_rst;
  logic [ND-1:0] domain_rst;
  logic          sys_ready;
  logic          lock_fail;
  logic [7:0]    lock_loss_count;
  logic [OW-1:0] dut_out;

  int checks   = 0;
  int failures = 0;

  int m_phase, m_t, m_retries, m_losses, m_q1, m_q2;

  nios_hps_system_pll_rst_seq #(
    .NUM_DOMAINS        (ND),
    .PLL_RST_CYCLES     (PRC),
    .LOCK_TIMEOUT       (LTO),
    .LOCK_STABLE_CYCLES (LSC),
    .RELEASE_GAP        (RG),
    .MAX_RETRIES        (MR)
  ) dut (
    .refclk          (refclk),
    .rst             (rst),
    .locked          (locked),
    .pll_rst         (pll_rst),
    .domain_rst      (domain_rst),
    .sys_ready       (sys_ready),
    .lock_fail       (lock_fail),
    .lock_loss_count (lock_loss_count)
  );

  always #5 refclk = ~refclk;

  assign dut_out = {pll_rst, domain_rst, sys_ready, lock_fail, lock_loss_count};

  // Phase/elapsed model: m_t counts cycles already spent in the current phase.
  task automatic model_edge();
    int ls;
    if (rst) begin
      m_phase = P_PLL; m_t = 0; m_retries = 0; m_losses = 0; m_q1 = 0; m_q2 = 0;
    end else begin
      ls   = m_q2;
      m_q2 = m_q1;
      m_q1 = int'(locked);
      case (m_phase)
        P_PLL: begin
          m_t++;
          if (m_t == PRC) begin m_phase = P_WAIT; m_t = 0; end
        end
        P_WAIT: begin
          if (ls != 0) begin
            m_phase = P_STABLE; m_t = 0;
          end else begin
            m_t++;
            if (m_t == LTO) begin
              m_t = 0;
              m_retries++;
              m_phase = (MR != 0 && m_retries > MR) ? P_FAIL : P_PLL;
            end
          end
        end
        P_STABLE: begin
          if (ls == 0) begin
            m_phase = P_WAIT; m_t = 0;
          end else begin
            m_t++;
            if (m_t == LSC) begin m_phase = P_REL; m_t = 0; end
          end
        end
        P_REL, P_RUN: begin
          if (ls == 0) begin
            m_phase = P_PLL; m_t = 0;
            m_losses = (m_losses < 255) ? m_losses + 1 : 255;
          end else if (m_phase == P_REL) begin
            m_t++;
            if (m_t > (ND - 1) * RG) begin m_phase = P_RUN; m_t = 0; m_retries = 0; end
          end
        end
        default: ;
      endcase
    end
  endtask

  function automatic logic [OW-1:0] model_out();
    logic [ND-1:0] dom;
    dom = '1;
    if (m_phase == P_REL) begin
      for (int i = 0; i < ND; i++) dom[i] = (m_t < i * RG);
    end else if (m_phase == P_RUN) begin
      dom = '0;
    end
    return {(m_phase == P_PLL || m_phase == P_FAIL), dom, (m_phase == P_RUN),
            (m_phase == P_FAIL), 8'(m_losses)};
  endfunction

  task automatic clk_cycle();
    @(posedge refclk);
    model_edge();
    #1;
  endtask

  // Leaves the bench at the start of cycle 0 (first cycle with rst low).
  task automatic do_reset(input logic lk);
    rst    = 1'b1;
    locked = lk;
    repeat (3) clk_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [OW-1:0] exp;
    rst    = 1'b1;
    locked = 1'b1;
    repeat (2) clk_cycle();
    @(negedge refclk);
    exp = {1'b1, {ND{1'b1}}, 1'b0, 1'b0, 8'd0};
    checks++;
    if (dut_out !== exp) begin
      failures++;
      $display("[TB] FAIL reset_values got=%h exp=%h", dut_out, exp);
    end
  endtask

  task automatic test_nominal();
    logic [OW-1:0] exp;
    logic [ND-1:0] dom;
    do_reset(1'b0);
    for (int c = 0; c <= 40; c++) begin
      locked = (c >= 10);
      @(negedge refclk);
      for (int i = 0; i < ND; i++) dom[i] = !(c >= 21 + 2 * i);
      exp = {(c <= 3), dom, (c >= 30), 1'b0, 8'd0};
      checks++;
      if (dut_out !== exp) begin
        failures++;
        $display("[TB] FAIL nominal cyc=%0d got=%h exp=%h", c, dut_out, exp);
      end
      clk_cycle();
    end
  endtask

  task automatic test_glitch();
    logic [OW-1:0] exp;
    logic [ND-1:0] dom;
    do_reset(1'b0);
    for (int c = 0; c <= 25; c++) begin
      locked = !(c >= 8 && c <= 10);
      @(negedge refclk);
      for (int i = 0; i < ND; i++) dom[i] = !(c >= 22 + 2 * i);
      exp = {(c <= 3), dom, 1'b0, 1'b0, 8'd0};
      checks++;
      if (dut_out !== exp) begin
        failures++;
        $display("[TB] FAIL stable_glitch cyc=%0d got=%h exp=%h", c, dut_out, exp);
      end
      clk_cycle();
    end
  endtask

  task automatic test_run_loss();
    logic [OW-1:0] exp;
    logic [ND-1:0] dom;
    do_reset(1'b0);
    for (int c = 0; c <= 80; c++) begin
      locked = (c >= 10 && c != 50);
      @(negedge refclk);
      for (int i = 0; i < ND; i++)
        dom[i] = !((c >= 21 + 2 * i && c < 53) || c >= 66 + 2 * i);
      exp = {(c <= 3 || (c >= 53 && c <= 56)), dom, ((c >= 30 && c < 53) || c >= 75),
             1'b0, 8'((c >= 53) ? 1 : 0)};
      checks++;
      if (dut_out !== exp) begin
        failures++;
        $display("[TB] FAIL run_loss cyc=%0d got=%h exp=%h", c, dut_out, exp);
      end
      clk_cycle();
    end
  endtask

  task automatic test_retry_fail();
    logic [OW-1:0] exp;
    do_reset(1'b0);
    for (int c = 0; c <= 129; c++) begin
      locked = (c >= 115);
      @(negedge refclk);
      exp = {(c <= 3 || (c >= 36 && c <= 39) || (c >= 72 && c <= 75) || c >= 108),
             {ND{1'b1}}, 1'b0, (c >= 108), 8'd0};
      checks++;
      if (dut_out !== exp) begin
        failures++;
        $display("[TB] FAIL retry_fail cyc=%0d got=%h exp=%h", c, dut_out, exp);
      end
      clk_cycle();
    end
    rst = 1'b1;
    clk_cycle();
    @(negedge refclk);
    checks++;
    if ({pll_rst, lock_fail} !== 2'b10) begin
      failures++;
      $display("[TB] FAIL fail_cleared_by_rst got=%b exp=10", {pll_rst, lock_fail});
    end
  endtask

  task automatic test_reset_mid_release();
    logic [OW-1:0] exp;
    logic [ND-1:0] dom;
    do_reset(1'b0);
    for (int c = 0; c <= 23; c++) begin
      locked = (c >= 10);
      clk_cycle();
    end
    rst = 1'b1;
    @(negedge refclk);
    exp = {1'b0, 5'b11100, 1'b0, 1'b0, 8'd0};
    checks++;
    if (dut_out !== exp) begin
      failures++;
      $display("[TB] FAIL mid_release_before got=%h exp=%h", dut_out, exp);
    end
    clk_cycle();
    @(negedge refclk);
    exp = {1'b1, {ND{1'b1}}, 1'b0, 1'b0, 8'd0};
    checks++;
    if (dut_out !== exp) begin
      failures++;
      $display("[TB] FAIL mid_release_reset got=%h exp=%h", dut_out, exp);
    end
    clk_cycle();
    rst = 1'b0;
    for (int c = 0; c <= 23; c++) begin
      @(negedge refclk);
      for (int i = 0; i < ND; i++) dom[i] = !(c >= 13 + 2 * i);
      exp = {(c <= 3), dom, (c >= 22), 1'b0, 8'd0};
      checks++;
      if (dut_out !== exp) begin
        failures++;
        $display("[TB] FAIL restart cyc=%0d got=%h exp=%h", c, dut_out, exp);
      end
      clk_cycle();
    end
  endtask

  task automatic test_saturation();
    int expect_cnt;
    do_reset(1'b1);
    repeat (30) clk_cycle();
    for (int k = 1; k <= 260; k++) begin
      locked = 1'b0;
      clk_cycle();
      locked = 1'b1;
      repeat (29) clk_cycle();
      @(negedge refclk);
      expect_cnt = (k > 255) ? 255 : k;
      checks++;
      if ({sys_ready, lock_loss_count} !== {1'b1, 8'(expect_cnt)}) begin
        failures++;
        $display("[TB] FAIL saturation loss=%0d got=%b/%0d exp=1/%0d",
                 k, sys_ready, lock_loss_count, expect_cnt);
      end
    end
    checks++;
    if (lock_loss_count !== 8'd255) begin
      failures++;
      $display("[TB] FAIL saturation_final got=%0d exp=255", lock_loss_count);
    end
  endtask

  task automatic test_random();
    int seg_len;
    logic seg_val;
    logic [OW-1:0] exp;
    do_reset(1'b0);
    seg_len = 0;
    seg_val = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (seg_len == 0) begin
        seg_val = ($urandom_range(0, 3) != 0);
        seg_len = $urandom_range(1, 48);
      end
      seg_len--;
      locked = seg_val;
      rst    = ($urandom_range(0, 399) == 0);
      @(negedge refclk);
      exp = model_out();
      checks++;
      if (dut_out !== exp) begin
        failures++;
        $display("[TB] FAIL random n=%0d got=%h exp=%h", n, dut_out, exp);
      end
      clk_cycle();
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_run_loss();
    test_retry_fail();
    test_reset_mid_release();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
